// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the round-robin grant controller.
// State encoding plus the explicit pointer wrap used by rr_grant_ctrl.
package rr_grant_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Wrap is explicit so non-power-of-2 requester counts rotate correctly.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned num);
        return (idx == num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/prio_lowest_search.sv
// Combinational lowest-set-index search over a request vector.
// Reports the index of the lowest set bit and whether any bit was set.
module prio_lowest_search #(
    parameter int ENTNUM = 4,
    parameter int ENTSEL = 2
) (
    input  logic [ENTNUM-1:0] vec,
    output logic [ENTSEL-1:0] idx,
    output logic              found
);

    // Scan from the top so the lowest set bit is the last to write idx.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = ENTNUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = ENTSEL'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter with a held, registered one-hot grant and its index.
// Optional grant timeout and tmo pulse when RR_GRANT_CTRL_TMO_EN is defined.
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int ENTNUM  = 4,
    parameter int ENTSEL  = 2,
    parameter int TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ENTNUM-1:0] req,
    input  logic              done,
    output logic [ENTNUM-1:0] gnt,
    output logic [ENTSEL-1:0] gnt_id,
    output logic              gnt_vld
`ifdef RR_GRANT_CTRL_TMO_EN
    ,
    output logic              tmo
`endif
);

    if (ENTNUM < 2 || TMO_CYC < 2 || ENTSEL < $clog2(ENTNUM)) begin : g_cfg_chk
        $error("rr_grant_ctrl: illegal parameter combination");
    end

    state_e            state;
    logic [ENTSEL-1:0] ptr;
    logic [ENTNUM-1:0] mask;
    logic [ENTNUM-1:0] masked;
    logic [ENTSEL-1:0] midx;
    logic [ENTSEL-1:0] uidx;
    logic              mfound;
    logic              any;
    logic [ENTSEL-1:0] win;
    logic              own_req;
    logic              rel;
    logic              arb;
    logic              tmo_hit;

    always_comb begin
        mask = '0;
        for (int i = 0; i < ENTNUM; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    assign masked = req & mask;

    prio_lowest_search #(.ENTNUM(ENTNUM), .ENTSEL(ENTSEL)) u_srch_masked (
        .vec   (masked),
        .idx   (midx),
        .found (mfound)
    );

    prio_lowest_search #(.ENTNUM(ENTNUM), .ENTSEL(ENTSEL)) u_srch_all (
        .vec   (req),
        .idx   (uidx),
        .found (any)
    );

    assign win     = mfound ? midx : uidx;
    assign own_req = |(req & gnt);
    assign rel     = done | ~own_req | tmo_hit;
    // Arbitrate from IDLE or on release, so a handover has no idle bubble.
    assign arb     = (state == IDLE) | ((state == BUSY) & rel);
    assign gnt_vld = |gnt;

`ifdef RR_GRANT_CTRL_TMO_EN
    localparam int CW = $clog2(TMO_CYC);

    logic [CW-1:0] cnt;

    assign tmo_hit = (state == BUSY) && (cnt == CW'(TMO_CYC - 1));
    assign tmo     = tmo_hit;

    // Saturating hold counter; cleared whenever arbitration happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (arb) begin
            cnt <= '0;
        end else if ((state == BUSY) && !tmo_hit) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else if (arb) begin
            if (any) begin
                state  <= BUSY;
                gnt    <= {{(ENTNUM-1){1'b0}}, 1'b1} << win;
                gnt_id <= win;
                ptr    <= ENTSEL'(next_ptr(int'(win), ENTNUM));
            end else begin
                state  <= IDLE;
                gnt    <= '0;
                gnt_id <= '0;
            end
        end
    end

endmodule
